// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy two-chute change payout with per-chute inventory
// Optional audit counters (paid_total, short_total) enabled by defining CHANGE_AUDIT_EN.
`timescale 1ns/1ps
module change_dispenser #(
  parameter int INV_W       = 6,
  parameter int INV5_INIT   = 20,
  parameter int INV10_INIT  = 20,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       change_req,
  input  logic             req_valid,
  output logic             req_ready,
  output logic             eject5,
  output logic             eject10,
  input  logic             hopper_ack,
  input  logic             refill_valid,
  input  logic [INV_W-1:0] refill5,
  input  logic [INV_W-1:0] refill10,
  input  logic             clr_fault,
  output logic             done,
  output logic [2:0]       short_amt,
  output logic             fault,
  output logic [INV_W-1:0] inv5,
  output logic [INV_W-1:0] inv10
`ifdef CHANGE_AUDIT_EN
  ,
  output logic [15:0]      paid_total,
  output logic [15:0]      short_total
`endif
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, PLAN, WAIT, FAULT} state_t;

  state_t        state;
  logic [2:0]    rem;
  logic [TW-1:0] timer;
  logic          take5;
  logic          take10;

  // Refill and a same-cycle coin drop net together, then clamp at full scale.
  function automatic logic [INV_W-1:0] inv_next(input logic [INV_W-1:0] cur,
                                                input logic [INV_W-1:0] add,
                                                input logic dec);
    logic [INV_W:0] sum;
    sum = {1'b0, cur} + (refill_valid ? {1'b0, add} : '0) - {{INV_W{1'b0}}, dec};
    inv_next = (sum > {1'b0, {INV_W{1'b1}}}) ? {INV_W{1'b1}} : sum[INV_W-1:0];
  endfunction

  always_comb begin
    take5  = (state == WAIT) && hopper_ack && eject5;
    take10 = (state == WAIT) && hopper_ack && eject10;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      rem       <= '0;
      timer     <= '0;
      req_ready <= 1'b1;
      eject5    <= 1'b0;
      eject10   <= 1'b0;
      done      <= 1'b0;
      short_amt <= '0;
      fault     <= 1'b0;
      inv5      <= INV_W'(INV5_INIT);
      inv10     <= INV_W'(INV10_INIT);
`ifdef CHANGE_AUDIT_EN
      paid_total  <= '0;
      short_total <= '0;
`endif
    end else begin
      done      <= 1'b0;
      short_amt <= '0;
      inv5      <= inv_next(inv5, refill5, take5);
      inv10     <= inv_next(inv10, refill10, take10);
      case (state)
        IDLE: begin
          if (req_valid && change_req >= 3'd1 && change_req <= 3'd4) begin
            rem       <= change_req;
            req_ready <= 1'b0;
            state     <= PLAN;
          end
        end
        PLAN: begin
          if (rem >= 3'd2 && inv10 != '0) begin
            eject10 <= 1'b1;
            timer   <= '0;
            state   <= WAIT;
          end else if (rem != 3'd0 && inv5 != '0) begin
            eject5 <= 1'b1;
            timer  <= '0;
            state  <= WAIT;
          end else begin
            // rem is either zero or the shortfall the hopper cannot cover
            done      <= 1'b1;
            short_amt <= rem;
            rem       <= '0;
            req_ready <= 1'b1;
            state     <= IDLE;
`ifdef CHANGE_AUDIT_EN
            short_total <= short_total + {13'd0, rem};
`endif
          end
        end
        WAIT: begin
          if (hopper_ack) begin
            eject5  <= 1'b0;
            eject10 <= 1'b0;
            rem     <= eject10 ? rem - 3'd2 : rem - 3'd1;
            state   <= PLAN;
`ifdef CHANGE_AUDIT_EN
            paid_total <= paid_total + (eject10 ? 16'd2 : 16'd1);
`endif
          end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
            eject5  <= 1'b0;
            eject10 <= 1'b0;
            fault   <= 1'b1;
            state   <= FAULT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        FAULT: begin
          if (clr_fault) begin
            fault     <= 1'b0;
            rem       <= '0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - directed bench for change_dispenser with greedy payout model
`timescale 1ns/1ps
module tb_change_dispenser;

  localparam int W = 6;
  localparam int MAXI = 63;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [2:0]   change_req = '0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         eject5, eject10;
  logic         hopper_ack = 1'b0;
  logic         refill_valid = 1'b0;
  logic [W-1:0] refill5 = '0;
  logic [W-1:0] refill10 = '0;
  logic         clr_fault = 1'b0;
  logic         done;
  logic [2:0]   short_amt;
  logic         fault;
  logic [W-1:0] inv5, inv10;

  change_dispenser dut (
    .clk(clk), .rst(rst), .change_req(change_req), .req_valid(req_valid),
    .req_ready(req_ready), .eject5(eject5), .eject10(eject10),
    .hopper_ack(hopper_ack), .refill_valid(refill_valid), .refill5(refill5),
    .refill10(refill10), .clr_fault(clr_fault), .done(done),
    .short_amt(short_amt), .fault(fault), .inv5(inv5), .inv10(inv10)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors = 0;
  int m_inv5 = 20;
  int m_inv10 = 20;
  bit m_fault = 1'b0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > MAXI) ? MAXI : v;
  endfunction

  // Inventory and fault state must track the model every cycle.
  always @(negedge clk) begin
    if (check_en) begin
      chk("inv5", 32'(inv5), m_inv5);
      chk("inv10", 32'(inv10), m_inv10);
      chk("fault", 32'(fault), 32'(m_fault));
      chk("one_chute", 32'(eject5 & eject10), 0);
    end
  end

  // Greedy payout model: predict each coin from model inventory, then the shortfall.
  task automatic request(input logic [2:0] code, input int lat, input int refill_on_ack,
                         output logic [2:0] short_got);
    int  rem;
    int  w;
    bit  use10;
    change_req = code;
    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("busy_ready", 32'(req_ready), 0);
    rem = code;
    while ((rem >= 2 && m_inv10 > 0) || (rem >= 1 && m_inv5 > 0)) begin
      use10 = (rem >= 2 && m_inv10 > 0);
      w = 0;
      while (!(eject5 || eject10) && w < 8) begin
        @(posedge clk); #1;
        w++;
      end
      chk("eject_latency", w, 1);
      chk("eject10", 32'(eject10), 32'(use10));
      chk("eject5", 32'(eject5), 32'(!use10));
      repeat (lat) begin
        @(posedge clk); #1;
        chk("eject_held", 32'(eject5 | eject10), 1);
      end
      hopper_ack = 1'b1;
      if (refill_on_ack > 0) begin
        refill_valid = 1'b1;
        refill5 = W'(refill_on_ack);
      end
      @(posedge clk); #1;
      hopper_ack = 1'b0;
      refill_valid = 1'b0;
      refill5 = '0;
      if (use10) begin
        m_inv10 = m_inv10 - 1;
        rem = rem - 2;
      end else begin
        rem = rem - 1;
      end
      m_inv5 = sat(m_inv5 + refill_on_ack - (use10 ? 0 : 1));
      chk("eject_release", 32'(eject5 | eject10), 0);
    end
    @(posedge clk); #1;
    chk("done", 32'(done), 1);
    chk("short_amt", 32'(short_amt), rem);
    short_got = short_amt;
    @(posedge clk); #1;
    chk("done_pulse", 32'(done), 0);
    chk("short_clear", 32'(short_amt), 0);
    chk("idle_ready", 32'(req_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] sh;
    logic [2:0] bad [4];
    bad = '{3'd0, 3'd5, 3'd6, 3'd7};

    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    check_en = 1'b1;
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_eject", 32'({eject5, eject10}), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_short", 32'(short_amt), 0);
    chk("rst_inv5", 32'(inv5), 20);
    chk("rst_inv10", 32'(inv10), 20);

    // 20rs with full stock: two 10rs coins
    request(3'b100, 2, 0, sh);
    chk("lit_inv10_18", 32'(inv10), 18);
    chk("lit_inv5_20", 32'(inv5), 20);

    // illegal codes and a stray ack while idle do nothing
    foreach (bad[i]) begin
      change_req = bad[i];
      req_valid = 1'b1;
      hopper_ack = (i == 0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      hopper_ack = 1'b0;
      repeat (2) begin
        chk("bad_code_quiet", 32'({eject5, eject10, done}), 0);
        chk("bad_code_ready", 32'(req_ready), 1);
        @(posedge clk); #1;
      end
    end

    // no ack: eject10 held for the timeout, then FAULT
    change_req = 3'b010;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 15; i++) begin
      chk("timeout_hold", 32'(eject10), 1);
      @(posedge clk); #1;
    end
    m_fault = 1'b1;
    chk("fault_eject", 32'({eject5, eject10}), 0);
    chk("fault_ready", 32'(req_ready), 0);
    repeat (3) @(posedge clk);
    #1 chk("fault_quiet", 32'({eject5, eject10, done}), 0);
    clr_fault = 1'b1;
    @(posedge clk); #1;
    clr_fault = 1'b0;
    m_fault = 1'b0;
    chk("clr_ready", 32'(req_ready), 1);
    chk("lit_fault_inv10", 32'(inv10), 18);

    // 15rs with stock: 10rs then 5rs
    request(3'b011, 1, 0, sh);
    // drain the 10rs chute
    for (int i = 0; i < 8; i++) request(3'b100, 0, 0, sh);
    request(3'b010, 0, 0, sh);
    chk("lit_inv10_0", 32'(inv10), 0);

    // 15rs with no 10rs coins: three 5rs coins
    request(3'b011, 0, 0, sh);
    chk("lit_inv5_16", 32'(inv5), 16);
    for (int i = 0; i < 5; i++) request(3'b011, 0, 0, sh);
    chk("lit_inv5_1", 32'(inv5), 1);

    // 20rs with one 5rs coin: pays 5rs, shortfall 15rs
    request(3'b100, 0, 0, sh);
    chk("lit_short_011", 32'(sh), 3);
    chk("lit_inv5_0", 32'(inv5), 0);

    // refill to full, then refill on the same cycle as a 5rs ack saturates
    refill_valid = 1'b1;
    refill5 = 6'd63;
    @(posedge clk); #1;
    refill_valid = 1'b0;
    refill5 = '0;
    m_inv5 = sat(m_inv5 + 63);
    request(3'b001, 0, 5, sh);
    chk("lit_sat_inv5", 32'(inv5), 63);

    // reset during the WAIT of a 20rs payout
    refill_valid = 1'b1;
    refill10 = 6'd5;
    @(posedge clk); #1;
    refill_valid = 1'b0;
    refill10 = '0;
    m_inv10 = sat(m_inv10 + 5);
    change_req = 3'b100;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("abort_eject_on", 32'(eject10), 1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    m_inv5 = 20;
    m_inv10 = 20;
    chk("abort_eject", 32'({eject5, eject10}), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_ready", 32'(req_ready), 1);
    chk("lit_abort_inv5", 32'(inv5), 20);
    chk("lit_abort_inv10", 32'(inv10), 20);
    repeat (3) @(posedge clk);
    #1 chk("abort_quiet", 32'({eject5, eject10, done}), 0);

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
